// File: rtl/fft16_pkg.sv
// fft16_pkg: shared constants, twiddle ROM and FSM state type for the 16-point FFT engine.
package fft16_pkg;
   localparam int N       = 16;
   localparam int LOG2N   = 4;
   localparam int DATA_W  = 12;
   localparam int GAIN_W  = LOG2N;
   localparam int OUT_W   = DATA_W + GAIN_W;
   localparam int TW_W    = 16;
   localparam int TW_FRAC = 14;
   // W16^k = cos(2pi k/16) - j sin(2pi k/16) in Q2.14, k = 0..7
   localparam logic signed [TW_W-1:0] TW_RE [8] = '{
      16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
      16'sd0, -16'sd6270, -16'sd11585, -16'sd15137};
   localparam logic signed [TW_W-1:0] TW_IM [8] = '{
      16'sd0, -16'sd6270, -16'sd11585, -16'sd15137,
      -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270};
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;
   function automatic logic [3:0] bitrev4(input logic [3:0] i_idx);
      return {i_idx[0], i_idx[1], i_idx[2], i_idx[3]};
   endfunction
endpackage

// File: rtl/fft16_iterative_butterfly.sv
// fft_butterfly_r2: combinational radix-2 DIT butterfly, A' = A + B*W, B' = A - B*W.
// Conjugating the twiddle turns the same datapath into the inverse transform.
module fft_butterfly_r2
   import fft16_pkg::*;
(
   input  logic signed [OUT_W-1:0] i_ar,
   input  logic signed [OUT_W-1:0] i_ai,
   input  logic signed [OUT_W-1:0] i_br,
   input  logic signed [OUT_W-1:0] i_bi,
   input  logic signed [TW_W-1:0]  i_wr,
   input  logic signed [TW_W-1:0]  i_wi,
   input  logic                    i_conj,
   output logic signed [OUT_W-1:0] o_ar,
   output logic signed [OUT_W-1:0] o_ai,
   output logic signed [OUT_W-1:0] o_br,
   output logic signed [OUT_W-1:0] o_bi
);
   localparam int PW = OUT_W + TW_W + 2;
   localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_FRAC - 1));
   logic signed [PW-1:0]    w_br, w_bi, w_wr, w_wi, w_pr, w_pi;
   logic signed [OUT_W-1:0] w_tr, w_ti;
   assign w_br = PW'(i_br);
   assign w_bi = PW'(i_bi);
   assign w_wr = PW'(i_wr);
   assign w_wi = i_conj ? -PW'(i_wi) : PW'(i_wi);
   // full-precision sums, then round half up back to Q0
   assign w_pr = w_br * w_wr - w_bi * w_wi + RND;
   assign w_pi = w_br * w_wi + w_bi * w_wr + RND;
   assign w_tr = OUT_W'(w_pr >>> TW_FRAC);
   assign w_ti = OUT_W'(w_pi >>> TW_FRAC);
   assign o_ar = i_ar + w_tr;
   assign o_ai = i_ai + w_ti;
   assign o_br = i_ar - w_tr;
   assign o_bi = i_ai - w_ti;
endmodule

// File: rtl/fft16_iterative.sv
// fft16_iterative: 16-point in-place radix-2 DIT FFT/IFFT, one butterfly per clock.
// Frame is loaded bit-reversed, 4 stages x 8 butterflies, results presented in parallel with a done pulse.
module fft16_iterative
   import fft16_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_mode,
   input  logic signed [DATA_W-1:0] i_data_real_in  [N],
   input  logic signed [DATA_W-1:0] i_data_imag_in  [N],
   output logic signed [OUT_W-1:0]  o_data_real_out [N],
   output logic signed [OUT_W-1:0]  o_data_imag_out [N],
   output logic                     o_done
);
   state_t                  r_state;
   logic                    r_mode;
   logic [4:0]              r_cnt;
   logic                    r_done;
   logic signed [OUT_W-1:0] r_re [N];
   logic signed [OUT_W-1:0] r_im [N];
   logic signed [OUT_W-1:0] r_out_re [N];
   logic signed [OUT_W-1:0] r_out_im [N];
   logic [1:0]              w_stage;
   logic [2:0]              w_b, w_k;
   logic [3:0]              w_top, w_bot;
   logic signed [OUT_W-1:0] w_ar, w_ai, w_br, w_bi;

   assign w_stage = r_cnt[4:3];
   assign w_b     = r_cnt[2:0];
   // top index = group*2*span + (b mod span); twiddle k = (b mod span)*(8>>stage)
   assign w_top = (w_stage == 2'd0) ? {w_b, 1'b0} :
                  (w_stage == 2'd1) ? {w_b[2:1], 1'b0, w_b[0]} :
                  (w_stage == 2'd2) ? {w_b[2], 1'b0, w_b[1:0]} : {1'b0, w_b};
   assign w_bot = w_top | (4'd1 << w_stage);
   assign w_k   = (w_stage == 2'd0) ? 3'd0 :
                  (w_stage == 2'd1) ? {w_b[0], 2'b00} :
                  (w_stage == 2'd2) ? {w_b[1:0], 1'b0} : w_b;

   fft_butterfly_r2 u_bfly (
      .i_ar   (r_re[w_top]),
      .i_ai   (r_im[w_top]),
      .i_br   (r_re[w_bot]),
      .i_bi   (r_im[w_bot]),
      .i_wr   (TW_RE[w_k]),
      .i_wi   (TW_IM[w_k]),
      .i_conj (r_mode),
      .o_ar   (w_ar),
      .o_ai   (w_ai),
      .o_br   (w_br),
      .o_bi   (w_bi)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_re[i]     <= '0;
            r_im[i]     <= '0;
            r_out_re[i] <= '0;
            r_out_im[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_mode  <= i_mode;
               r_state <= S_LOAD;
            end
            S_LOAD: begin
               for (int i = 0; i < N; i++) begin
                  r_re[bitrev4(4'(i))] <= OUT_W'(i_data_real_in[i]);
                  r_im[bitrev4(4'(i))] <= OUT_W'(i_data_imag_in[i]);
               end
               r_cnt   <= '0;
               r_state <= S_CALC;
            end
            S_CALC: begin
               r_re[w_top] <= w_ar;
               r_im[w_top] <= w_ai;
               r_re[w_bot] <= w_br;
               r_im[w_bot] <= w_bi;
               r_cnt       <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) r_state <= S_OUT;
            end
            S_OUT: begin
               // inverse divides by N (floor) on the way out
               for (int i = 0; i < N; i++) begin
                  r_out_re[i] <= r_mode ? r_re[i] >>> GAIN_W : r_re[i];
                  r_out_im[i] <= r_mode ? r_im[i] >>> GAIN_W : r_im[i];
               end
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_data_real_out = r_out_re;
   assign o_data_imag_out = r_out_im;
   assign o_done          = r_done;
endmodule

// File: tb/tb_fft16_iterative.sv
// tb_fft16_iterative: directed vector table plus hand-written start/reset sequences.
module tb_fft16_iterative;
   import fft16_pkg::*;

   typedef int arr_t [16];
   typedef struct packed {
      logic                 mode;
      logic [3:0]           tol;
      logic [N-1:0][15:0]   re_in;
      logic [N-1:0][15:0]   im_in;
      logic [N-1:0][15:0]   re_exp;
      logic [N-1:0][15:0]   im_exp;
   } vec_t;

   localparam arr_t Z      = '{default: 0};
   localparam arr_t C100   = '{default: 100};
   localparam arr_t CM200  = '{default: -200};
   localparam arr_t IMP0   = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   localparam arr_t IMP1   = '{0, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   localparam arr_t IMPM   = '{-200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   localparam arr_t DC1600 = '{1600, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   localparam arr_t S1_RE  = '{100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38, 0, 38, 71, 92};
   localparam arr_t S1_IM  = '{0, -38, -71, -92, -100, -92, -71, -38, 0, 38, 71, 92, 100, 92, 71, 38};
   localparam arr_t I1_RE  = '{6, 5, 4, 2, 0, -3, -5, -6, -7, -6, -5, -3, 0, 2, 4, 5};
   localparam arr_t I1_IM  = '{0, 2, 4, 5, 6, 5, 4, 2, 0, -3, -5, -6, -7, -6, -5, -3};
   localparam arr_t TONE   = '{1000, 924, 707, 383, 0, -383, -707, -924, -1000, -924, -707, -383, 0, 383, 707, 924};
   localparam arr_t TONE_X = '{0, 8000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8000};

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic                     mode = 1'b0;
   logic signed [DATA_W-1:0] din_re [N];
   logic signed [DATA_W-1:0] din_im [N];
   logic signed [OUT_W-1:0]  dout_re [N];
   logic signed [OUT_W-1:0]  dout_im [N];
   logic                     done;
   int                       checks = 0;
   int                       errors = 0;
   vec_t                     vecs [7];

   always #5 clk = ~clk;

   fft16_iterative dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_start         (start),
      .i_mode          (mode),
      .i_data_real_in  (din_re),
      .i_data_imag_in  (din_im),
      .o_data_real_out (dout_re),
      .o_data_imag_out (dout_im),
      .o_done          (done)
   );

   function automatic vec_t mk(input logic m, input int tol, input arr_t ri, input arr_t ii,
                               input arr_t re, input arr_t ie);
      vec_t v;
      v.mode = m;
      v.tol  = 4'(tol);
      for (int i = 0; i < N; i++) begin
         v.re_in[i]  = 16'(ri[i]);
         v.im_in[i]  = 16'(ii[i]);
         v.re_exp[i] = 16'(re[i]);
         v.im_exp[i] = 16'(ie[i]);
      end
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp, input int tol);
      checks++;
      if (act > exp + tol || act < exp - tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   task automatic apply(input vec_t v);
      mode = v.mode;
      for (int i = 0; i < N; i++) begin
         din_re[i] = 12'($signed(v.re_in[i]));
         din_im[i] = 12'($signed(v.im_in[i]));
      end
   endtask

   task automatic chk_out(input string tag, input vec_t v);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s re[%0d]", tag, i), int'(dout_re[i]), int'($signed(v.re_exp[i])), int'(v.tol));
         chk($sformatf("%s im[%0d]", tag, i), int'(dout_im[i]), int'($signed(v.im_exp[i])), int'(v.tol));
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int lat;
      @(negedge clk);
      apply(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      chk({tag, " latency"}, lat, 34, 0);
      @(negedge clk);
      chk({tag, " done pulse"}, int'(done), 0, 0);
      chk_out(tag, v);
   endtask

   initial begin
      int lat, gap, ndone, first;
      vecs[0] = mk(1'b0, 0, IMP0, Z, C100, Z);
      vecs[1] = mk(1'b0, 0, C100, Z, DC1600, Z);
      vecs[2] = mk(1'b1, 0, DC1600, Z, C100, Z);
      vecs[3] = mk(1'b0, 0, IMP1, Z, S1_RE, S1_IM);
      vecs[4] = mk(1'b1, 0, IMP1, Z, I1_RE, I1_IM);
      vecs[5] = mk(1'b0, 4, TONE, Z, TONE_X, Z);
      vecs[6] = mk(1'b0, 0, Z, IMPM, Z, CM200);
      for (int i = 0; i < N; i++) begin
         din_re[i] = '0;
         din_im[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset done", int'(done), 0, 0);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("reset re[%0d]", i), int'(dout_re[i]), 0, 0);
         chk($sformatf("reset im[%0d]", i), int'(dout_im[i]), 0, 0);
      end
      rst_n = 1'b1;

      for (int v = 0; v < 7; v++) run_vec($sformatf("vec%0d", v), vecs[v]);

      // start pulsed mid-CALC is ignored
      @(negedge clk);
      apply(vecs[1]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      first = 0;
      for (int c = 1; c <= 80; c++) begin
         start = (c == 10);
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first == 0) first = c;
         end
      end
      start = 1'b0;
      chk("midcalc start done count", ndone, 1, 0);
      chk("midcalc start latency", first, 34, 0);
      chk_out("midcalc start", vecs[1]);

      // reset mid-CALC aborts and clears outputs
      @(negedge clk);
      apply(vecs[3]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort done", int'(done), 0, 0);
      chk("abort re[0]", int'(dout_re[0]), 0, 0);
      chk("abort re[15]", int'(dout_re[15]), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort no done", ndone, 0, 0);
      run_vec("after abort", vecs[3]);

      // start held high restarts on the first IDLE cycle
      @(negedge clk);
      apply(vecs[1]);
      start = 1'b1;
      @(negedge clk);
      wait_done(lat);
      chk("held start first latency", lat, 34, 0);
      @(negedge clk);
      chk("held start done pulse", int'(done), 0, 0);
      wait_done(gap);
      start = 1'b0;
      chk("held start gap", gap + 1, 35, 0);
      chk_out("held start", vecs[1]);
      repeat (40) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
